// File: rtl/partition_scheduler.sv
// Range scheduler for the quick-sort engine: splits the finished range at the pivot,
// stacks the non-trivial halves (larger first) and pops the next range. Optional: PARTITION_PEAK_DEPTH_EN.
module partition_scheduler #(
  parameter int K = 10,
  parameter int S = $clog2(K) + 1,
  parameter int D = K / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_mem,
  input  logic                   start_partition,
  input  logic [S-1:0]           pivot_idx,
  output logic [S-1:0]           cur_lo,
  output logic [S-1:0]           cur_hi,
  output logic                   finish_partition,
  output logic                   finish,
  output logic [$clog2(D+1)-1:0] depth,
  output logic                   overflow,
`ifdef PARTITION_PEAK_DEPTH_EN
  output logic [$clog2(D+1)-1:0] peak_depth,
`endif
  output logic                   range_err
);
  localparam int DW = $clog2(D + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(D);

  // Sequencing: strict one cycle per non-IDLE state, so the pulse latency is fixed.
  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_PUSH_A, S_PUSH_B, S_POP} state_t;

  state_t           state_q, state_d;
  logic             start_d_q;
  logic [S-1:0]     p_q, p_d;
  logic [S-1:0]     a_lo_q, a_lo_d, a_hi_q, a_hi_d, b_lo_q, b_lo_d, b_hi_q, b_hi_d;
  logic             a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [S-1:0]     cur_lo_q, cur_lo_d, cur_hi_q, cur_hi_d;
  logic [DW-1:0]    depth_q, depth_d, top_idx;
  logic             ovf_q, ovf_d, err_q, err_d, fp_q, fp_d, fin_q, fin_d;
  logic [2*S-1:0]   stack_q [D];
  logic             push_req, stack_we;
  logic [2*S-1:0]   push_entry;
  logic [S:0]       lo_x, hi_x, p_x, left_len, right_len;
  logic             in_range, left_vld, right_vld;
`ifdef PARTITION_PEAK_DEPTH_EN
  logic [DW-1:0]    peak_q, peak_d;
`endif

  // Sub-range evaluation is done one bit wider so p=0 and p=K-1 cannot wrap.
  always_comb begin
    lo_x      = {1'b0, cur_lo_q};
    hi_x      = {1'b0, cur_hi_q};
    p_x       = {1'b0, p_q};
    in_range  = (p_x >= lo_x) && (p_x <= hi_x);
    left_vld  = in_range && (p_x >= lo_x + (S+1)'(2));
    right_vld = in_range && (hi_x >= p_x + (S+1)'(2));
    left_len  = p_x - lo_x;
    right_len = hi_x - p_x;
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    a_lo_d     = a_lo_q;
    a_hi_d     = a_hi_q;
    a_vld_d    = a_vld_q;
    b_lo_d     = b_lo_q;
    b_hi_d     = b_hi_q;
    b_vld_d    = b_vld_q;
    cur_lo_d   = cur_lo_q;
    cur_hi_d   = cur_hi_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    fp_d       = 1'b0;
    fin_d      = 1'b0;
    push_req   = 1'b0;
    stack_we   = 1'b0;
    push_entry = '0;
    top_idx    = depth_q - DW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_partition && !start_d_q) begin
          p_d     = pivot_idx;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!in_range) err_d = 1'b1;
        if (left_len >= right_len) begin
          a_lo_d = cur_lo_q;          a_hi_d = p_q - S'(1); a_vld_d = left_vld;
          b_lo_d = p_q + S'(1);       b_hi_d = cur_hi_q;    b_vld_d = right_vld;
        end else begin
          a_lo_d = p_q + S'(1);       a_hi_d = cur_hi_q;    a_vld_d = right_vld;
          b_lo_d = cur_lo_q;          b_hi_d = p_q - S'(1); b_vld_d = left_vld;
        end
        state_d = S_PUSH_A;
      end
      S_PUSH_A: begin
        push_req   = a_vld_q;
        push_entry = {a_lo_q, a_hi_q};
        state_d    = S_PUSH_B;
      end
      S_PUSH_B: begin
        push_req   = b_vld_q;
        push_entry = {b_lo_q, b_hi_q};
        state_d    = S_POP;
      end
      S_POP: begin
        if (depth_q != '0) begin
          {cur_lo_d, cur_hi_d} = stack_q[top_idx];
          depth_d              = top_idx;
          fp_d                 = 1'b1;
        end else begin
          fin_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (push_req) begin
      if (depth_q == DEPTH_FULL) begin
        ovf_d = 1'b1;
      end else begin
        stack_we = 1'b1;
        depth_d  = depth_q + DW'(1);
      end
    end
  end

`ifdef PARTITION_PEAK_DEPTH_EN
  assign peak_d     = (depth_q > peak_q) ? depth_q : peak_q;
  assign peak_depth = peak_q;
`endif

  always_ff @(posedge clk) begin
    start_d_q <= start_partition;
    if (reset || reset_mem) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      a_lo_q   <= '0;
      a_hi_q   <= '0;
      a_vld_q  <= 1'b0;
      b_lo_q   <= '0;
      b_hi_q   <= '0;
      b_vld_q  <= 1'b0;
      cur_lo_q <= '0;
      cur_hi_q <= S'(K - 1);
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      fp_q     <= 1'b0;
      fin_q    <= 1'b0;
`ifdef PARTITION_PEAK_DEPTH_EN
      peak_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      a_lo_q   <= a_lo_d;
      a_hi_q   <= a_hi_d;
      a_vld_q  <= a_vld_d;
      b_lo_q   <= b_lo_d;
      b_hi_q   <= b_hi_d;
      b_vld_q  <= b_vld_d;
      cur_lo_q <= cur_lo_d;
      cur_hi_q <= cur_hi_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      fp_q     <= fp_d;
      fin_q    <= fin_d;
`ifdef PARTITION_PEAK_DEPTH_EN
      peak_q   <= peak_d;
`endif
    end
  end

  // Stack contents need no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (stack_we && !(reset || reset_mem)) stack_q[depth_q] <= push_entry;
  end

  assign cur_lo           = cur_lo_q;
  assign cur_hi           = cur_hi_q;
  assign finish_partition = fp_q;
  assign finish           = fin_q;
  assign depth            = depth_q;
  assign overflow         = ovf_q;
  assign range_err        = err_q;
endmodule

// File: doc/partition_scheduler.md
Name: partition_scheduler

Overview:
- Range scheduler for the quick-sort engine. It sits beside the sort datapath and answers the control FSM's start_partition request.
- It takes the pivot position from the just-completed partition pass and pushes the non-trivial sub-ranges onto an explicit range stack. It then pops the next range into cur_lo/cur_hi.
- It answers with a one-cycle finish_partition pulse (more work) or a one-cycle finish pulse (stack exhausted, sort complete).

Parameters:
- K, 10, number of elements sorted; K >= 2.
- S, $clog2(K)+1, index word width.
- D, K/2, range stack depth in entries; each entry is {lo, hi}, 2*S bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- reset_mem  input  1  synchronous re-initialise from control; level.
- start_partition  input  1  level-high request from control, held for the whole partition state.
- pivot_idx  input  S  final pivot position of the current range; valid on the first cycle start_partition is high.
- cur_lo  output  S  low index of the range to sort next.
- cur_hi  output  S  high index of the range to sort next.
- finish_partition  output  1  one-cycle pulse: new range loaded.
- finish  output  1  one-cycle pulse: no ranges remain.
- depth  output  $clog2(D+1)  current stack occupancy.
- overflow  output  1  sticky: a push was dropped because the stack was full.
- range_err  output  1  sticky: pivot_idx was outside [cur_lo, cur_hi].

Behaviour:
- Reset (reset or reset_mem high at a clock edge):
  - cur_lo=0, cur_hi=K-1, depth=0, finish_partition=0, finish=0, overflow=0, range_err=0.
  - FSM goes to IDLE.
  - This aborts any sequence in progress; no pulse is issued.
  - reset has priority over reset_mem; both have the same effect.
- Start detection: internal registered start_partition_d. A request is start_partition & ~start_partition_d. A level held high for any length produces exactly one sequence.
- FSM states: IDLE, EVAL, PUSH_A, PUSH_B, POP. Exactly one cycle in each non-IDLE state.
  - IDLE: on a request, latch p=pivot_idx, go to EVAL.
  - EVAL: compute sub-ranges using S+1-bit arithmetic so that p=0 and p=K-1 never wrap.
    - Left=[cur_lo, p-1], valid iff p >= cur_lo+2.
    - Right=[p+1, cur_hi], valid iff cur_hi >= p+2.
    - If p<cur_lo or p>cur_hi: set range_err, both sub-ranges invalid.
    - Define the larger sub-range as A and the other as B; on a length tie, Left is A.
  - PUSH_A: push A if valid, else no-op.
  - PUSH_B: push B if valid, else no-op. Larger-first ordering bounds stack growth.
  - POP, stack non-empty: pop the top entry into cur_lo/cur_hi, depth-1; finish_partition=1 during the next cycle.
  - POP, stack empty: cur_lo/cur_hi unchanged; finish=1 during the next cycle.
  - After POP, return to IDLE.
- Latency: request seen at edge t; pulse is high in cycle t+5 for exactly one cycle. This latency is fixed regardless of how many pushes are valid.
- finish and finish_partition are never both high.
- The pulse must precede control leaving s3. Control leaves on the pulse, so start_partition falls after the pulse; dropping start_partition early does not abort the sequence.
- A push when depth==D is dropped: stack contents unchanged, overflow set until reset or reset_mem.
- A new request while the FSM is not in IDLE is ignored; this is not a legal stimulus.
- Stack is a register array indexed by depth; LIFO; no read-before-write hazard, since push and pop never occur in the same cycle.

Optional Feature:
- Macro: PARTITION_PEAK_DEPTH_EN.
- Defined: adds output peak_depth, $clog2(D+1) bits, holding the maximum depth reached since the last reset or reset_mem. It updates in the cycle after a push raises depth above the current peak.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: pulse reset_mem one cycle -> cur_lo=0, cur_hi=9, depth=0, no pulses, flags 0.
- Range [0,9], pivot_idx=4:
  - Stimulus: hold start_partition high.
  - Response: push [5,9], then push [0,3], then pop [0,3].
  - Check: cur_lo=0, cur_hi=3, depth=1, finish_partition high in cycle t+5 only.
- Range [0,3], pivot_idx=0 (stack holds [5,9]): Left invalid, no wrap; push [1,3], pop -> cur=[1,3], depth=1, range_err=0.
- Range [5,6], pivot_idx=5, stack empty: both sub-ranges invalid -> finish=1 in cycle t+5, finish_partition=0, cur unchanged=[5,6].
- start_partition held high 12 cycles -> exactly one pulse. pivot_idx=12 on [0,9] -> range_err=1, no pushes.
- D=1 override, range [0,9], pivot_idx=4 -> first push succeeds, second is dropped, overflow=1; pop yields [5,9]. With PARTITION_PEAK_DEPTH_EN defined, peak_depth=1.
